// File: rtl/fpu_pkg.sv
// Shared types and constants for the floating-point add/sub datapath.
package fpu_pkg;

    // Rounding-mode encodings seen on rnd_mode
    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    // Widest formats the unpacked operand can carry
    localparam int FP_EXP_MAX = 16;
    localparam int FP_MAN_MAX = 64;
    localparam int FP_W_MAX   = 1 + FP_EXP_MAX + FP_MAN_MAX;

    // Unpacked operand; exp/mant are zero-extended from the configured widths
    typedef struct packed {
        logic                  sign;
        logic [FP_EXP_MAX-1:0] exp;
        logic [FP_MAN_MAX-1:0] mant;
        logic                  is_zero;
        logic                  is_inf;
        logic                  is_nan;
    } fp_unpacked_t;

    // Canonical quiet NaN: +, all-ones exponent, mantissa MSB set, rest zero
    function automatic logic [FP_W_MAX-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_W_MAX-1:0] q;
        q = '0;
        for (int i = 0; i < FP_W_MAX; i++) begin
            if (i >= man_w && i < man_w + exp_w) q[i] = 1'b1;
        end
        q[man_w-1] = 1'b1;
        return q;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    // Scan upward so the highest set bit writes last and wins
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor: unpack/swap, align/add,
// normalise/round/pack. DAZ on inputs, FTZ on outputs, global stall.
module fpu_addsub_pipe import fpu_pkg::*; #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_sub,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         inexact,
    output logic         invalid
);

    localparam int STAGES = 3;
    localparam int XW     = MAN_W + 4;            // hidden + mantissa + G/R/S
    localparam int SW     = MAN_W + 5;            // XW plus carry-out
    localparam int EW2    = EXP_W + 2;            // signed exponent headroom
    localparam int LZW    = $clog2(XW + 1);

    localparam logic [W-1:0]            QNAN      = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]        EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0]        SH_MAX    = EXP_W'(MAN_W + 3);
    localparam logic signed [EW2-1:0]   E_OVF     = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0]   E_MIN     = EW2'(1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man_big;
        logic [MAN_W:0]   man_small;
        logic [EXP_W-1:0] diff;
        logic             eff_sub;
        logic             rm;
        logic             nan;
        logic             inf;
        logic             zero;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sum;
        logic             rm;
        logic             nan;
        logic             inf;
        logic             zero;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            advance;
    logic            accept;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic            ovf_q, unf_q, inx_q, inv_q;

    assign out_valid = vld_pipe[STAGES];
    assign advance   = ~vld_pipe[STAGES] | out_ready;
    assign in_ready  = advance & ~rst;
    assign accept    = in_valid & in_ready;

    assign overflow  = vld_pipe[STAGES] & ovf_q;
    assign underflow = vld_pipe[STAGES] & unf_q;
    assign inexact   = vld_pipe[STAGES] & inx_q;
    assign invalid   = vld_pipe[STAGES] & inv_q;

    // Denormals collapse to signed zero here, so no later stage sees them
    function automatic fp_unpacked_t unpack(input logic [W-1:0] x, input logic flip);
        fp_unpacked_t     u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e         = x[W-2:MAN_W];
        m         = x[MAN_W-1:0];
        u.sign    = x[W-1] ^ flip;
        u.exp     = FP_EXP_MAX'(e);
        u.is_zero = (e == '0);
        u.mant    = u.is_zero ? '0 : FP_MAN_MAX'(m);
        u.is_inf  = (e == EXP_ONES) && (m == '0);
        u.is_nan  = (e == EXP_ONES) && (m != '0);
        return u;
    endfunction

    // ---------------- stage 1: unpack, classify, order by magnitude
    fp_unpacked_t ua, ub;
    logic         swap;

    // Put the larger magnitude in the "big" slot so stage 2 never goes negative
    always_comb begin
        ua   = unpack(a, 1'b0);
        ub   = unpack(b, op_sub);
        swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};
        s1_d.exp       = swap ? ub.exp[EXP_W-1:0] : ua.exp[EXP_W-1:0];
        s1_d.man_big   = swap ? {~ub.is_zero, ub.mant[MAN_W-1:0]}
                              : {~ua.is_zero, ua.mant[MAN_W-1:0]};
        s1_d.man_small = swap ? {~ua.is_zero, ua.mant[MAN_W-1:0]}
                              : {~ub.is_zero, ub.mant[MAN_W-1:0]};
        s1_d.diff      = swap ? ub.exp[EXP_W-1:0] - ua.exp[EXP_W-1:0]
                              : ua.exp[EXP_W-1:0] - ub.exp[EXP_W-1:0];
        s1_d.eff_sub   = ua.sign ^ ub.sign;
        s1_d.zero      = ua.is_zero & ub.is_zero;
        // zero+zero is only negative when both are -0
        s1_d.sign      = s1_d.zero ? (ua.sign & ub.sign) : (swap ? ub.sign : ua.sign);
        s1_d.nan       = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & s1_d.eff_sub);
        s1_d.inf       = ua.is_inf | ub.is_inf;
        s1_d.rm        = rnd_mode;
    end

    // ---------------- stage 2: align the smaller operand, add or subtract
    logic [XW-1:0]   small_ext, aligned;
    logic [2*XW-1:0] sh;

    // Bits shifted past the sticky position are ORed into it
    always_comb begin
        small_ext = {s1_q.man_small, 3'b000};
        sh        = {small_ext, {XW{1'b0}}} >> s1_q.diff;
        if (s1_q.diff >= SH_MAX)
            aligned = {{(XW-1){1'b0}}, |small_ext};
        else
            aligned = sh[2*XW-1:XW] | {{(XW-1){1'b0}}, |sh[XW-1:0]};
        s2_d.sum  = s1_q.eff_sub ? ({1'b0, s1_q.man_big, 3'b000} - {1'b0, aligned})
                                 : ({1'b0, s1_q.man_big, 3'b000} + {1'b0, aligned});
        s2_d.sign = s1_q.sign;
        s2_d.exp  = s1_q.exp;
        s2_d.rm   = s1_q.rm;
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        s2_d.zero = s1_q.zero;
    end

    // ---------------- stage 3: normalise, round, pack
    logic [LZW-1:0]          lz;
    logic [XW-1:0]           norm;
    logic [MAN_W:0]          keep;
    logic [2:0]              grs;
    logic                    up, rc;
    logic [MAN_W+1:0]        rnd;
    logic [MAN_W-1:0]        frac;
    logic signed [EW2-1:0]   e_pre, e_fin;
    logic [W-1:0]            res_d;
    logic                    ovf_d, unf_d, inx_d, inv_d;

    fpu_lzc #(.WIDTH(XW), .CNT_W(LZW)) u_lzc (
        .vec (s2_q.sum[XW-1:0]),
        .cnt (lz)
    );

    // Carry-out takes a 1-bit right shift; otherwise shift left by the LZ count
    always_comb begin
        if (s2_q.sum[SW-1]) begin
            norm  = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
            e_pre = EW2'(s2_q.exp) + EW2'(1);
        end else begin
            norm  = s2_q.sum[XW-1:0] << lz;
            e_pre = EW2'(s2_q.exp) - EW2'(lz);
        end
        keep  = norm[XW-1:3];
        grs   = norm[2:0];
        up    = (s2_q.rm == RM_RNE) & grs[2] & (grs[1] | grs[0] | keep[0]);
        rnd   = {1'b0, keep} + (MAN_W+2)'(up);
        rc    = rnd[MAN_W+1];
        frac  = rc ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        e_fin = e_pre + EW2'(rc);

        res_d = {s2_q.sign, e_fin[EXP_W-1:0], frac};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = |grs;
        inv_d = 1'b0;

        if (s2_q.nan) begin
            res_d = QNAN;
            inx_d = 1'b0;
            inv_d = 1'b1;
        end else if (s2_q.inf) begin
            res_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            inx_d = 1'b0;
        end else if (s2_q.zero) begin
            res_d = {s2_q.sign, {(W-1){1'b0}}};
            inx_d = 1'b0;
        end else if (s2_q.sum == '0) begin
            // exact cancellation is +0 in both supported modes
            res_d = '0;
            inx_d = 1'b0;
        end else if (e_fin >= E_OVF) begin
            res_d = (s2_q.rm == RM_RNE) ? {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}}
                                        : {s2_q.sign, EXP_MAXF, {MAN_W{1'b1}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (e_fin < E_MIN) begin
            res_d = {s2_q.sign, {(W-1){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    // Valid shift register and stage registers; everything freezes on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            result   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result   <= res_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
            inv_q    <= inv_d;
        end
    end

endmodule

// File: doc/fpu_addsub_pipe.md
Name: fpu_addsub_pipe

Overview:
Parametrised, pipelined IEEE-754 floating-point adder/subtractor. It is the successor to the combinational single-precision adder. It adds configurable exponent/mantissa widths, an add/sub mode, two rounding modes, a valid/ready handshake with backpressure, and a full exception flag set. It sits between operand-issue logic and the FPU result writeback.

Parameters:
EXP_W, 8, exponent field width (8 = single, 11 = double)
MAN_W, 23, stored mantissa field width (23 = single, 52 = double)
W, EXP_W+MAN_W+1, total operand width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
a  input  W  operand A, IEEE bit pattern
b  input  W  operand B, IEEE bit pattern
op_sub  input  1  0: A+B, 1: A-B
rnd_mode  input  1  0: round-to-nearest-even, 1: round-toward-zero
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  sum/difference, IEEE bit pattern
overflow  output  1  rounded magnitude exceeded largest finite value
underflow  output  1  nonzero result below smallest normal, flushed to zero
inexact  output  1  rounding discarded nonzero bits
invalid  output  1  NaN operand, or inf-inf of effective subtraction

Behaviour:
- Reset (async, rst=1): all stage valid bits clear; out_valid=0; result=0; all flags=0. in_ready=1 while rst=0 and the pipe is empty.
- Reset asserted mid-operation discards all in-flight operations. No partial result appears after release.
- Three register stages. Latency is exactly 3 cycles from the accept edge (in_valid & in_ready) to out_valid when out_ready is held high. Throughput is 1 operation per cycle.
- Stall is global: advance = !s3_valid | out_ready, and in_ready = advance.
- While advance=0, every stage holds and result/flags stay stable.
- out_valid & !out_ready must keep result constant until the transfer.
- Order is preserved. No operation is lost or duplicated.
- Stage 1 (unpack):
  - Effective B sign = b.sign ^ op_sub.
  - Denormal inputs are treated as signed zero (DAZ).
  - Detect zero, inf and NaN.
  - Swap so |A| >= |B|.
  - Exponent difference is computed unsigned, EXP_W bits.
- Stage 2 (align/add):
  - Shift the smaller mantissa (hidden bit restored) right by the difference, keeping guard/round/sticky.
  - A shift >= MAN_W+3 leaves only the sticky bit.
  - Add or subtract to a MAN_W+5-bit result.
- Stage 3 (normalise/round/pack):
  - Leading-zero count, then left shift, or a 1-bit right shift on carry-out.
  - RNE: round up if G & (R | S | lsb).
  - RTZ: truncate.
  - Rounding carry renormalises and increments the exponent.
  - inexact = G|R|S.
- Overflow: biased exponent >= 2^EXP_W-1 after rounding sets overflow=1 and inexact=1. Result is ±inf under RNE and ±max-finite under RTZ.
- Underflow: nonzero result with biased exponent < 1 gives signed zero, underflow=1, inexact=1 (FTZ).
- Exact cancellation gives +0 under both modes. (+0)+(+0)=+0; (-0)+(-0)=-0.
- Specials:
  - Any NaN gives the canonical qNaN {0, all-ones exp, 1 then zeros} with invalid=1.
  - inf - inf (effective) gives the same qNaN with invalid=1.
  - inf ± finite gives that inf, with no flags.
- Flags are valid only with out_valid; they are 0 when out_valid=0.

Decomposition:
- Package fpu_pkg holds:
  - rounding-mode constants RM_RNE and RM_RTZ;
  - a typedef for the unpacked operand {sign, exp, mant, is_zero, is_inf, is_nan};
  - a function for the canonical qNaN pattern, parametrised by EXP_W/MAN_W.
- One sub-module, fpu_lzc, is a parametrised leading-zero counter used in stage 3.

Test Plan:
- 0x3FC00000 + 0x40100000, op_sub=0, RNE -> 0x40700000 (3.75) after exactly 3 cycles; no flags set.
- 0x7F266B7D + 0x7F266B7D (about 2.21e38 each): RNE -> 0x7F800000, overflow=1, inexact=1; RTZ -> 0x7F7FFFFF, overflow=1.
- 0x00800001 with op_sub=1 against 0x00800000 -> 0x00000000, underflow=1, inexact=1; 0x40400000 - 0x40400000 -> 0x00000000 with no flags.
- Specials:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000, invalid=1.
  - 0x00000001 + 0x3F800000 -> 0x3F800000 (DAZ), no flags.
- Backpressure: issue 5 back-to-back ops and drop out_ready for cycles 4-5. Required: in_ready=0 during the stall, result held stable, and all 5 results delivered in order with none duplicated.
- Reset mid-stream: assert rst with 3 ops in flight. Required: out_valid=0 immediately, and no stale result after release; the next op completes 3 cycles after its accept.
